mmio_resp_arb: RTL and testbench
================================

// Module: mmio_resp_arb
// PURPOSE
// - Registered MMIO response arbiter with bus-miss timeout; sits between the L2 MMIO port and the peripheral slaves.
// - Selects the first non-READY slave response and returns it to L2 with data and OK code.
// - Times out unclaimed requests and returns FAULT plus a bus-exception code, so a missing slave cannot hang the CPU.
// PARAMETERS
// - NSLV     6     number of slave response ports (index 0 = highest priority)
// - TMO_CYC  255   cycles in WAIT with no slave response before FAULT (1..65535)
// - EXC_CODE 16'h8004  low 16 bits of busExc raised on timeout
// PORTS
// - clock       in   1         core clock (the only clock)
// - reset       in   1         asynchronous, active-high reset
// - mmioAddr    in   32        request address from L2
// - mmioOpm     in   5         request opcode from L2; 0 = idle
// - slvData     in   NSLV*64   slave read data; slave i at [64*i+63:64*i]
// - slvOK       in   NSLV*2    slave OK codes; slave i at [2*i+1:2*i]
// - mmioInData  out  64        response data to L2
// - mmioOK      out  2         response code to L2 (UMEM_OK_*)
// - busExc      out  64        bus exception to CPU; {48'h0, EXC_CODE} for one cycle on timeout, else 0
// - missAddr    out  32        last timed-out address (MMIO_ARB_MISSLOG_EN only)
// - missCount   out  16        saturating timeout count (MMIO_ARB_MISSLOG_EN only)
// BEHAVIOUR
// - Reset: state=IDLE, mmioInData=0, mmioOK=UMEM_OK_READY, busExc=0, missAddr=0, missCount=0, timer=0.
// - OK codes: READY=0, OK=1, HOLD=2, FAULT=3. All outputs are registered, so a response appears one cycle after slave selection.
// - IDLE: outputs READY/0. When mmioOpm!=0, latch mmioAddr into reqAddr, clear timer, go to WAIT.
// - WAIT: select the lowest index i with slvOK[i]!=READY.
//   - Selected OK: register slvData[i] and OK, go to RESP.
//   - Selected HOLD or FAULT: forward the code and data each cycle, clear timer, stay in WAIT.
//   - No selection: mmioOK=HOLD and timer++. When timer==TMO_CYC-1, go to ERR.
// - RESP: hold the latched data/OK stable. Ignore slave changes. Return to IDLE when mmioOpm==0.
// - ERR: mmioOK=FAULT, mmioInData=0. busExc is asserted only in the first ERR cycle. Return to IDLE when mmioOpm==0.
// - mmioOpm==0 in WAIT means the request was abandoned: go to IDLE next cycle, no FAULT.
// - mmioAddr!=reqAddr in WAIT with mmioOpm!=0: treat as a new request. Relatch the address, clear the timer, stay in WAIT.
// - Multiple non-READY slaves: lowest index wins. This is deterministic and involves no arbitration state.
// - Slave responding in the same cycle the timer expires: the slave response wins; no ERR.
// - Async reset mid-transaction: immediate return to the reset values, independent of the clock.
// - timer is 16 bits and never wraps, because ERR is entered first.
// CONFIGURATION
// - MMIO_ARB_MISSLOG_EN defined:
//   - On ERR entry, missAddr<=reqAddr and missCount<=missCount+1, saturating at 16'hFFFF.
//   - Under `ifndef SYNTHESIS`, print "MMIO Bus Miss A=%X" once per ERR entry.
// - MMIO_ARB_MISSLOG_EN undefined: missAddr and missCount are tied to 0; no log logic and no display.
// STRUCTURE
// - Shared package: UMEM_OK_READY/OK/HOLD/FAULT, UV64_00, UV48_00 and the state enum encoding (IDLE=0, WAIT=1, RESP=2, ERR=3).
// - One sub-module, mmio_prio_sel: combinational NSLV-way priority selector that outputs {hit, idx, data, ok}.
// - Top level holds the FSM, timer, address latch, output registers and the optional miss log.
// TESTING
// - Slave 2 answers OK, data 64'h1234 at cycle 3 of a read to 0xF000_E010 -> mmioOK=OK, data=0x1234 one cycle later; held until opm=0, then READY.
// - No slave answers, TMO_CYC=8 -> HOLD for 8 cycles, then FAULT; busExc={48'h0,16'h8004} for exactly 1 cycle; missAddr=0xF000_E010, missCount=1.
// - Slaves 1 and 4 both OK in the same cycle with data 0xAA / 0xBB -> data=0xAA.
// - Slave 0 HOLD for 300 cycles, then OK, TMO_CYC=255 -> no FAULT; OK is delivered.
// - Reset asserted while in WAIT with timer=5 -> outputs READY/0 immediately; a fresh request times out after the full TMO_CYC.
// - Build without MMIO_ARB_MISSLOG_EN, repeat the timeout test -> FAULT occurs; missAddr=0 and missCount=0.

Source files
------------

// File: rtl/mmio_resp_arb_pkg.sv
// Package: mmio_resp_arb_pkg
// Purpose : shared response codes, zero constants, FSM state encoding and a
//           small helper for index widths used by the MMIO response arbiter.
// Ports   : none (package)
package mmio_resp_arb_pkg;

   localparam logic [1:0] UMEM_OK_READY = 2'd0;
   localparam logic [1:0] UMEM_OK_OK    = 2'd1;
   localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
   localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

   localparam logic [63:0] UV64_00 = 64'h0;
   localparam logic [47:0] UV48_00 = 48'h0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } arb_state_t;

   // Width of a slave index; a single-slave build still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mmio_resp_arb_if.sv
// Interface: mmio_resp_arb_if
// Purpose  : bundles the L2 request, slave response and arbiter response
//            signals of the MMIO response arbiter.
// Signals  : mmioAddr/mmioOpm (L2 request), slvData/slvOK (slave responses),
//            mmioInData/mmioOK (response to L2), busExc (exception to CPU),
//            missAddr/missCount (optional miss log).
// Modports : master - L2/peripheral side driving requests and slave responses
//            slave  - the arbiter
interface mmio_resp_arb_if #(
   parameter int NSLV = 6
);
   logic [31:0]         mmioAddr;
   logic [4:0]          mmioOpm;
   logic [NSLV*64-1:0]  slvData;
   logic [NSLV*2-1:0]   slvOK;
   logic [63:0]         mmioInData;
   logic [1:0]          mmioOK;
   logic [63:0]         busExc;
   logic [31:0]         missAddr;
   logic [15:0]         missCount;

   modport master (
      output mmioAddr, mmioOpm, slvData, slvOK,
      input  mmioInData, mmioOK, busExc, missAddr, missCount
   );

   modport slave (
      input  mmioAddr, mmioOpm, slvData, slvOK,
      output mmioInData, mmioOK, busExc, missAddr, missCount
   );
endinterface

// File: rtl/mmio_prio_sel.sv
// Module : mmio_prio_sel
// Purpose: combinational fixed-priority selector over NSLV slave responses;
//          the lowest-index slave whose code is not READY wins.
// Ports  : slv_data/slv_ok (packed slave responses, slave i at 64*i / 2*i),
//          hit (any slave responding), idx/data/ok (winning slave).
module mmio_prio_sel
   import mmio_resp_arb_pkg::*;
#(
   parameter int NSLV = 6,
   localparam int IDXW = idx_width(NSLV)
) (
   input  logic [NSLV*64-1:0] slv_data,
   input  logic [NSLV*2-1:0]  slv_ok,
   output logic               hit,
   output logic [IDXW-1:0]    idx,
   output logic [63:0]        data,
   output logic [1:0]         ok
);

   // Scan from the top down so the lowest responding index is written last.
   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      data = UV64_00;
      ok   = UMEM_OK_READY;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if (slv_ok[2*i +: 2] != UMEM_OK_READY) begin
            hit  = 1'b1;
            idx  = IDXW'(i);
            data = slv_data[64*i +: 64];
            ok   = slv_ok[2*i +: 2];
         end
      end
   end

endmodule

// File: rtl/mmio_resp_arb.sv
// Module : mmio_resp_arb
// Purpose: registered MMIO response arbiter between the L2 MMIO port and the
//          peripheral slaves, with a bus-miss timeout that returns FAULT and
//          raises a one-cycle bus exception so a missing slave cannot hang
//          the CPU.
// Ports  : clock, reset (async, active-high); bus (mmio_resp_arb_if.slave)
//          carrying the request, slave responses and all registered outputs.
// Options: MMIO_ARB_MISSLOG_EN - keeps the last timed-out address and a
//          saturating timeout count; otherwise missAddr/missCount read 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no request; outputs READY/0
// ST_WAIT | request latched; forwarding HOLD/FAULT or counting timeout
// ST_RESP | OK response latched; held until L2 drops the opcode
// ST_ERR  | timeout; FAULT held until L2 drops the opcode
module mmio_resp_arb
   import mmio_resp_arb_pkg::*;
#(
   parameter int          NSLV     = 6,
   parameter int          TMO_CYC  = 255,
   parameter logic [15:0] EXC_CODE = 16'h8004
) (
   input logic             clock,
   input logic             reset,
   mmio_resp_arb_if.slave  bus
);

   localparam int IDXW = idx_width(NSLV);
   localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

   arb_state_t        state;
   logic [31:0]       req_addr;
   logic [15:0]       timer;
   logic [63:0]       data_q;
   logic [1:0]        ok_q;
   logic [63:0]       exc_q;

   logic              sel_hit;
   logic [IDXW-1:0]   sel_idx;
   logic [63:0]       sel_data;
   logic [1:0]        sel_ok;

   logic              req_live;
   logic              same_req;
   logic              err_entry;

   mmio_prio_sel #(.NSLV(NSLV)) u_sel (
      .slv_data (bus.slvData),
      .slv_ok   (bus.slvOK),
      .hit      (sel_hit),
      .idx      (sel_idx),
      .data     (sel_data),
      .ok       (sel_ok)
   );

`ifndef SYNTHESIS
   always_comb begin
      assert (!sel_hit || sel_ok == bus.slvOK[{sel_idx, 1'b0} +: 2]);
   end
`endif

   assign req_live  = (bus.mmioOpm != 5'd0);
   assign same_req  = req_live && (bus.mmioAddr == req_addr);
   // A slave answering on the expiry cycle takes precedence over the timeout.
   assign err_entry = (state == ST_WAIT) && same_req && !sel_hit && (timer == TMO_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         req_addr <= 32'h0;
         timer    <= 16'h0;
         data_q   <= UV64_00;
         ok_q     <= UMEM_OK_READY;
         exc_q    <= UV64_00;
      end else begin
         exc_q <= UV64_00;
         case (state)
            ST_IDLE: begin
               data_q <= UV64_00;
               ok_q   <= UMEM_OK_READY;
               if (req_live) begin
                  // Accepted requests report HOLD until a slave decides.
                  req_addr <= bus.mmioAddr;
                  timer    <= 16'h0;
                  ok_q     <= UMEM_OK_HOLD;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!req_live) begin
                  data_q <= UV64_00;
                  ok_q   <= UMEM_OK_READY;
                  state  <= ST_IDLE;
               end else if (!same_req) begin
                  req_addr <= bus.mmioAddr;
                  timer    <= 16'h0;
                  data_q   <= UV64_00;
                  ok_q     <= UMEM_OK_HOLD;
               end else if (sel_hit) begin
                  data_q <= sel_data;
                  ok_q   <= sel_ok;
                  timer  <= 16'h0;
                  if (sel_ok == UMEM_OK_OK) begin
                     state <= ST_RESP;
                  end
               end else if (err_entry) begin
                  data_q <= UV64_00;
                  ok_q   <= UMEM_OK_FAULT;
                  exc_q  <= {UV48_00, EXC_CODE};
                  state  <= ST_ERR;
               end else begin
                  data_q <= UV64_00;
                  ok_q   <= UMEM_OK_HOLD;
                  timer  <= timer + 16'd1;
               end
            end
            ST_RESP: begin
               if (!req_live) begin
                  data_q <= UV64_00;
                  ok_q   <= UMEM_OK_READY;
                  state  <= ST_IDLE;
               end
            end
            ST_ERR: begin
               data_q <= UV64_00;
               ok_q   <= UMEM_OK_FAULT;
               if (!req_live) begin
                  ok_q  <= UMEM_OK_READY;
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.mmioInData = data_q;
   assign bus.mmioOK     = ok_q;
   assign bus.busExc     = exc_q;

`ifdef MMIO_ARB_MISSLOG_EN
   logic [31:0] miss_addr_q;
   logic [15:0] miss_count_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         miss_addr_q  <= 32'h0;
         miss_count_q <= 16'h0;
      end else if (err_entry) begin
         miss_addr_q <= req_addr;
         if (miss_count_q != 16'hFFFF) begin
            miss_count_q <= miss_count_q + 16'd1;
         end
`ifndef SYNTHESIS
         $display("MMIO Bus Miss A=%X", req_addr);
`endif
      end
   end

   assign bus.missAddr  = miss_addr_q;
   assign bus.missCount = miss_count_q;
`else
   assign bus.missAddr  = 32'h0;
   assign bus.missCount = 16'h0;
`endif

endmodule

// File: tb/tb_mmio_resp_arb.sv
// Testbench for mmio_resp_arb: directed scenarios with hand-computed
// expectations, built with TMO_CYC = 8.
module tb_mmio_resp_arb;

   localparam logic [1:0] C_READY = 2'd0;
   localparam logic [1:0] C_OK    = 2'd1;
   localparam logic [1:0] C_HOLD  = 2'd2;
   localparam logic [1:0] C_FAULT = 2'd3;
   localparam logic [63:0] C_EXC  = {48'h0, 16'h8004};
   localparam logic [31:0] A_REQ  = 32'hF000_E010;
   localparam logic [31:0] A_ALT  = 32'hF000_E020;

   logic clock = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   logic [31:0] exp_maddr = 32'h0;
   logic [15:0] exp_mcnt  = 16'h0;

   mmio_resp_arb_if #(.NSLV(6)) bus ();

   mmio_resp_arb #(.NSLV(6), .TMO_CYC(8), .EXC_CODE(16'h8004)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_slv(input int i, input logic [1:0] ok, input logic [63:0] d);
      bus.slvOK[2*i +: 2]    = ok;
      bus.slvData[64*i +: 64] = d;
   endtask

   task automatic clear_slv();
      bus.slvOK   = '0;
      bus.slvData = '0;
   endtask

   task automatic test_reset();
      n_vec++; if (bus.mmioOK !== C_READY) begin n_err++; $display("FAIL reset_ok: got %0d want %0d", bus.mmioOK, C_READY); end
      n_vec++; if (bus.mmioInData !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.mmioInData); end
      n_vec++; if (bus.busExc !== 64'h0) begin n_err++; $display("FAIL reset_exc: got %h want 0", bus.busExc); end
      n_vec++; if (bus.missAddr !== 32'h0) begin n_err++; $display("FAIL reset_maddr: got %h want 0", bus.missAddr); end
      n_vec++; if (bus.missCount !== 16'h0) begin n_err++; $display("FAIL reset_mcnt: got %0d want 0", bus.missCount); end
   endtask

   task automatic test_ok_read();
      bus.mmioAddr = A_REQ; bus.mmioOpm = 5'd1;
      tick(); tick(); tick();
      n_vec++; if (bus.mmioOK !== C_HOLD) begin n_err++; $display("FAIL read_wait_ok: got %0d want %0d", bus.mmioOK, C_HOLD); end
      set_slv(2, C_OK, 64'h1234);
      tick();
      n_vec++; if (bus.mmioOK !== C_OK) begin n_err++; $display("FAIL read_ok: got %0d want %0d", bus.mmioOK, C_OK); end
      n_vec++; if (bus.mmioInData !== 64'h1234) begin n_err++; $display("FAIL read_data: got %h want 1234", bus.mmioInData); end
      clear_slv(); set_slv(0, C_OK, 64'hDEAD);
      tick(); tick();
      n_vec++; if (bus.mmioOK !== C_OK || bus.mmioInData !== 64'h1234) begin n_err++; $display("FAIL read_held: got %0d/%h want %0d/1234", bus.mmioOK, bus.mmioInData, C_OK); end
      bus.mmioOpm = 5'd0; clear_slv();
      tick();
      n_vec++; if (bus.mmioOK !== C_READY || bus.mmioInData !== 64'h0) begin n_err++; $display("FAIL read_release: got %0d/%h want %0d/0", bus.mmioOK, bus.mmioInData, C_READY); end
      tick();
   endtask

   // Request and count observed HOLD cycles until the code changes.
   task automatic count_holds(output int holds);
      holds = 0;
      tick();
      while (bus.mmioOK === C_HOLD && holds < 40) begin
         holds++;
         tick();
      end
   endtask

   task automatic test_timeout();
      int holds;
      bus.mmioAddr = A_REQ; bus.mmioOpm = 5'd2;
      count_holds(holds);
`ifdef MMIO_ARB_MISSLOG_EN
      exp_maddr = A_REQ; exp_mcnt = exp_mcnt + 16'd1;
`endif
      n_vec++; if (holds != 8) begin n_err++; $display("FAIL tmo_holds: got %0d want 8", holds); end
      n_vec++; if (bus.mmioOK !== C_FAULT || bus.mmioInData !== 64'h0) begin n_err++; $display("FAIL tmo_fault: got %0d/%h want %0d/0", bus.mmioOK, bus.mmioInData, C_FAULT); end
      n_vec++; if (bus.busExc !== C_EXC) begin n_err++; $display("FAIL tmo_exc: got %h want %h", bus.busExc, C_EXC); end
      tick();
      n_vec++; if (bus.busExc !== 64'h0 || bus.mmioOK !== C_FAULT) begin n_err++; $display("FAIL tmo_exc_once: got %h/%0d want 0/%0d", bus.busExc, bus.mmioOK, C_FAULT); end
      n_vec++; if (bus.missAddr !== exp_maddr) begin n_err++; $display("FAIL tmo_maddr: got %h want %h", bus.missAddr, exp_maddr); end
      n_vec++; if (bus.missCount !== exp_mcnt) begin n_err++; $display("FAIL tmo_mcnt: got %0d want %0d", bus.missCount, exp_mcnt); end
      bus.mmioOpm = 5'd0;
      tick();
      n_vec++; if (bus.mmioOK !== C_READY) begin n_err++; $display("FAIL tmo_release: got %0d want %0d", bus.mmioOK, C_READY); end
      tick();
   endtask

   task automatic test_priority();
      bus.mmioAddr = A_ALT; bus.mmioOpm = 5'd1;
      tick();
      set_slv(3, C_HOLD, 64'h33); set_slv(5, C_OK, 64'h55);
      tick();
      n_vec++; if (bus.mmioOK !== C_HOLD || bus.mmioInData !== 64'h33) begin n_err++; $display("FAIL prio_hold: got %0d/%h want %0d/33", bus.mmioOK, bus.mmioInData, C_HOLD); end
      clear_slv(); set_slv(1, C_OK, 64'hAA); set_slv(4, C_OK, 64'hBB);
      tick();
      n_vec++; if (bus.mmioOK !== C_OK || bus.mmioInData !== 64'hAA) begin n_err++; $display("FAIL prio_ok: got %0d/%h want %0d/aa", bus.mmioOK, bus.mmioInData, C_OK); end
      clear_slv(); bus.mmioOpm = 5'd0;
      tick(); tick();
   endtask

   task automatic test_hold_long();
      int bad = 0;
      bus.mmioAddr = A_REQ; bus.mmioOpm = 5'd1;
      tick();
      set_slv(0, C_HOLD, 64'h55);
      for (int c = 0; c < 300; c++) begin
         tick();
         if (bus.mmioOK !== C_HOLD || bus.mmioInData !== 64'h55 || bus.busExc !== 64'h0) bad++;
      end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL hold_long: got %0d bad cycles want 0", bad); end
      set_slv(0, C_OK, 64'h77);
      tick();
      n_vec++; if (bus.mmioOK !== C_OK || bus.mmioInData !== 64'h77) begin n_err++; $display("FAIL hold_long_ok: got %0d/%h want %0d/77", bus.mmioOK, bus.mmioInData, C_OK); end
      clear_slv(); bus.mmioOpm = 5'd0;
      tick(); tick();
   endtask

   task automatic test_expiry_race();
      bus.mmioAddr = A_REQ; bus.mmioOpm = 5'd1;
      tick();
      for (int c = 0; c < 7; c++) tick();
      n_vec++; if (bus.mmioOK !== C_HOLD) begin n_err++; $display("FAIL race_pre: got %0d want %0d", bus.mmioOK, C_HOLD); end
      set_slv(5, C_OK, 64'hCC);
      tick();
      n_vec++; if (bus.mmioOK !== C_OK || bus.mmioInData !== 64'hCC || bus.busExc !== 64'h0) begin n_err++; $display("FAIL race_ok: got %0d/%h/%h want %0d/cc/0", bus.mmioOK, bus.mmioInData, bus.busExc, C_OK); end
      n_vec++; if (bus.missCount !== exp_mcnt) begin n_err++; $display("FAIL race_mcnt: got %0d want %0d", bus.missCount, exp_mcnt); end
      clear_slv(); bus.mmioOpm = 5'd0;
      tick(); tick();
   endtask

   task automatic test_abandon();
      int bad = 0;
      bus.mmioAddr = A_REQ; bus.mmioOpm = 5'd3;
      tick(); tick(); tick();
      bus.mmioOpm = 5'd0;
      tick();
      n_vec++; if (bus.mmioOK !== C_READY) begin n_err++; $display("FAIL abandon_ok: got %0d want %0d", bus.mmioOK, C_READY); end
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus.mmioOK !== C_READY || bus.busExc !== 64'h0) bad++;
      end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL abandon_quiet: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_relatch();
      int holds;
      bus.mmioAddr = A_REQ; bus.mmioOpm = 5'd1;
      tick();
      for (int c = 0; c < 6; c++) tick();
      bus.mmioAddr = A_ALT;
      count_holds(holds);
`ifdef MMIO_ARB_MISSLOG_EN
      exp_maddr = A_ALT; exp_mcnt = exp_mcnt + 16'd1;
`endif
      n_vec++; if (holds != 8) begin n_err++; $display("FAIL relatch_holds: got %0d want 8", holds); end
      n_vec++; if (bus.mmioOK !== C_FAULT) begin n_err++; $display("FAIL relatch_fault: got %0d want %0d", bus.mmioOK, C_FAULT); end
      tick();
      n_vec++; if (bus.missAddr !== exp_maddr || bus.missCount !== exp_mcnt) begin n_err++; $display("FAIL relatch_log: got %h/%0d want %h/%0d", bus.missAddr, bus.missCount, exp_maddr, exp_mcnt); end
      bus.mmioOpm = 5'd0;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      int holds;
      bus.mmioAddr = A_REQ; bus.mmioOpm = 5'd1;
      tick();
      for (int c = 0; c < 5; c++) tick();
      reset = 1'b1;
      #2;
      n_vec++; if (bus.mmioOK !== C_READY || bus.mmioInData !== 64'h0) begin n_err++; $display("FAIL rstmid_out: got %0d/%h want %0d/0", bus.mmioOK, bus.mmioInData, C_READY); end
      n_vec++; if (bus.missCount !== 16'h0 || bus.missAddr !== 32'h0) begin n_err++; $display("FAIL rstmid_log: got %h/%0d want 0/0", bus.missAddr, bus.missCount); end
      reset = 1'b0;
      exp_maddr = 32'h0; exp_mcnt = 16'h0;
      count_holds(holds);
`ifdef MMIO_ARB_MISSLOG_EN
      exp_maddr = A_REQ; exp_mcnt = 16'd1;
`endif
      n_vec++; if (holds != 8) begin n_err++; $display("FAIL rstmid_holds: got %0d want 8", holds); end
      n_vec++; if (bus.mmioOK !== C_FAULT || bus.busExc !== C_EXC) begin n_err++; $display("FAIL rstmid_fault: got %0d/%h want %0d/%h", bus.mmioOK, bus.busExc, C_FAULT, C_EXC); end
      tick();
      n_vec++; if (bus.missAddr !== exp_maddr || bus.missCount !== exp_mcnt) begin n_err++; $display("FAIL rstmid_log2: got %h/%0d want %h/%0d", bus.missAddr, bus.missCount, exp_maddr, exp_mcnt); end
      bus.mmioOpm = 5'd0;
      tick(); tick();
   endtask

   initial begin
      reset = 1'b1;
      bus.mmioAddr = 32'h0;
      bus.mmioOpm  = 5'd0;
      clear_slv();
      #12;
      test_reset();
      reset = 1'b0;
      tick();
      test_ok_read();
      test_timeout();
      test_priority();
      test_hold_long();
      test_expiry_race();
      test_abandon();
      test_relatch();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
